// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the decode/control unit:
// opcode constants, two-word instruction detection and fetch FSM states.
package fetch_stage_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_NOP = 5'd0;
  localparam logic [OPC_W-1:0] OP_LDM = 5'd13;
  localparam logic [OPC_W-1:0] OP_JZ  = 5'd16;
  localparam logic [OPC_W-1:0] OP_JN  = 5'd17;
  localparam logic [OPC_W-1:0] OP_JC  = 5'd18;
  localparam logic [OPC_W-1:0] OP_JMP = 5'd19;
  localparam logic [OPC_W-1:0] OP_SHL = 5'd30;
  localparam logic [OPC_W-1:0] OP_SHR = 5'd31;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [0:0] {
    S_INSTR = 1'b0,
    S_IMM   = 1'b1
  } fetch_state_t;

  // Opcodes whose immediate follows in the next memory word.
  function automatic logic is_two_word(input logic [OPC_W-1:0] op);
    return (op == OP_LDM) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: reset vector, load-target (highest priority), increment
// modulo 2^PC_W, otherwise hold.
module pc_reg #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_target,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives imem address from the PC, assembles two-word
// instructions and registers the IF/ID buffer consumed by decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jump_taken,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instr_out,
  output logic [4:0]      opcode,
  output logic [15:0]     imm_out,
  output logic [PC_W-1:0] pc_next_out,
  output logic            valid_out
);

  fetch_state_t    r_state, w_state_next;
  logic [15:0]     r_pending, w_pending_next;
  logic [15:0]     r_instr, w_instr_next;
  logic [15:0]     r_imm, w_imm_next;
  logic [PC_W-1:0] r_pc_next, w_pc_next_next;
  logic            r_valid, w_valid_next;
  logic [PC_W-1:0] w_pc;
  logic [PC_W-1:0] w_pc_plus1;
  logic            w_pc_load;
  logic            w_pc_inc;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (jump_taken),
    .i_target (jump_target),
    .i_inc    (w_pc_inc),
    .o_pc     (w_pc)
  );

  assign w_pc_load  = jump_taken;
  assign w_pc_plus1 = w_pc + PC_W'(1);
  assign imem_addr  = w_pc;

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_instr_next   = r_instr;
    w_imm_next     = r_imm;
    w_pc_next_next = r_pc_next;
    w_valid_next   = r_valid;
    w_pc_inc       = 1'b0;

    // Redirect beats stall; a bubble keeps pc_next_out unchanged.
    if (w_pc_load) begin
      w_state_next   = S_INSTR;
      w_pending_next = NOP_WORD;
      w_instr_next   = NOP_WORD;
      w_imm_next     = 16'h0000;
      w_valid_next   = 1'b0;
    end else if (!stall) begin
      w_pc_inc = 1'b1;
      unique case (r_state)
        S_INSTR: begin
          if (is_two_word(imem_data[15:11])) begin
            w_pending_next = imem_data;
            w_instr_next   = NOP_WORD;
            w_imm_next     = 16'h0000;
            w_valid_next   = 1'b0;
            w_state_next   = S_IMM;
          end else begin
            w_instr_next   = imem_data;
            w_imm_next     = 16'h0000;
            w_pc_next_next = w_pc_plus1;
            w_valid_next   = 1'b1;
          end
        end
        S_IMM: begin
          w_instr_next   = r_pending;
          w_imm_next     = imem_data;
          w_pc_next_next = w_pc_plus1;
          w_valid_next   = 1'b1;
          w_state_next   = S_INSTR;
        end
        default: w_state_next = S_INSTR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_INSTR;
      r_pending <= NOP_WORD;
      r_instr   <= NOP_WORD;
      r_imm     <= 16'h0000;
      r_pc_next <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_instr   <= w_instr_next;
      r_imm     <= w_imm_next;
      r_pc_next <= w_pc_next_next;
      r_valid   <= w_valid_next;
    end
  end

  assign instr_out   = r_instr;
  assign opcode      = r_instr[15:11];
  assign imm_out     = r_imm;
  assign pc_next_out = r_pc_next;
  assign valid_out   = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table through a scoreboard
// queue, plus hand sequences for PC wrap and asynchronous reset mid-immediate.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jump_taken;
  logic [15:0] jump_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic [4:0]  opcode;
  logic [15:0] imm_out;
  logic [15:0] pc_next_out;
  logic        valid_out;

  logic [15:0] mem [0:65535];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        stall;
    logic        jump;
    logic [15:0] target;
    logic [15:0] e_instr;
    logic [15:0] e_imm;
    logic [15:0] e_pcn;
    logic        e_valid;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vecs [17];
  vec_t sb_q [$];

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr_out   (instr_out),
    .opcode      (opcode),
    .imm_out     (imm_out),
    .pc_next_out (pc_next_out),
    .valid_out   (valid_out)
  );

  function automatic vec_t mk(input logic s, input logic j, input logic [15:0] t,
                              input logic [15:0] ei, input logic [15:0] em,
                              input logic [15:0] ep, input logic ev,
                              input logic [15:0] ea);
    vec_t v;
    v.stall = s; v.jump = j; v.target = t;
    v.e_instr = ei; v.e_imm = em; v.e_pcn = ep; v.e_valid = ev; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp_v);
    end
  endtask

  // Drive one cycle (called 1 time unit after a rising edge), push the
  // expectation, then pop and compare 1 time unit after the next edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    stall       = v.stall;
    jump_taken  = v.jump;
    jump_target = v.target;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".instr"},  instr_out, e.e_instr);
    chk({tag, ".opcode"}, {11'd0, opcode}, {11'd0, e.e_instr[15:11]});
    chk({tag, ".imm"},    imm_out, e.e_imm);
    chk({tag, ".pcn"},    pc_next_out, e.e_pcn);
    chk({tag, ".valid"},  {15'd0, valid_out}, {15'd0, e.e_valid});
    chk({tag, ".addr"},   imem_addr, e.e_addr);
    $display("%s: stall=%0b jump=%0b instr=%04h imm=%04h pcn=%04h valid=%0b addr=%04h",
             tag, v.stall, v.jump, instr_out, imm_out, pc_next_out, valid_out, imem_addr);
    stall      = 1'b0;
    jump_taken = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0]     = 16'hC800;
    mem[1]     = 16'h1800;
    mem[2]     = 16'h2000;
    mem[3]     = 16'h0800;
    mem[4]     = 16'h6800;
    mem[5]     = 16'hBEEF;
    mem[6]     = 16'h1000;
    mem[7]     = 16'h6801;
    mem[8]     = 16'h1234;
    mem[16'h40] = 16'h2800;
    mem[16'h41] = 16'h3000;
    mem[16'hFFFF] = 16'hF800;

    //          stall jump target   instr     imm       pcn       v     addr
    vecs[0]  = mk(0, 0, 16'h0000, 16'hC800, 16'h0000, 16'h0001, 1, 16'h0001);
    vecs[1]  = mk(0, 0, 16'h0000, 16'h1800, 16'h0000, 16'h0002, 1, 16'h0002);
    vecs[2]  = mk(0, 0, 16'h0000, 16'h2000, 16'h0000, 16'h0003, 1, 16'h0003);
    vecs[3]  = mk(0, 0, 16'h0000, 16'h0800, 16'h0000, 16'h0004, 1, 16'h0004);
    vecs[4]  = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 0, 16'h0005);
    vecs[5]  = mk(0, 0, 16'h0000, 16'h6800, 16'hBEEF, 16'h0006, 1, 16'h0006);
    vecs[6]  = mk(1, 0, 16'h0000, 16'h6800, 16'hBEEF, 16'h0006, 1, 16'h0006);
    vecs[7]  = mk(1, 0, 16'h0000, 16'h6800, 16'hBEEF, 16'h0006, 1, 16'h0006);
    vecs[8]  = mk(1, 0, 16'h0000, 16'h6800, 16'hBEEF, 16'h0006, 1, 16'h0006);
    vecs[9]  = mk(0, 0, 16'h0000, 16'h1000, 16'h0000, 16'h0007, 1, 16'h0007);
    vecs[10] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0007, 0, 16'h0008);
    vecs[11] = mk(0, 1, 16'h0040, 16'h0000, 16'h0000, 16'h0007, 0, 16'h0040);
    vecs[12] = mk(0, 0, 16'h0000, 16'h2800, 16'h0000, 16'h0041, 1, 16'h0041);
    vecs[13] = mk(1, 1, 16'h0004, 16'h0000, 16'h0000, 16'h0041, 0, 16'h0004);
    vecs[14] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0041, 0, 16'h0005);
    vecs[15] = mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0041, 0, 16'h0005);
    vecs[16] = mk(0, 0, 16'h0000, 16'h6800, 16'hBEEF, 16'h0006, 1, 16'h0006);

    rst = 1'b1; stall = 1'b0; jump_taken = 1'b0; jump_target = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.instr", instr_out, 16'h0000);
    chk("reset.imm",   imm_out, 16'h0000);
    chk("reset.pcn",   pc_next_out, 16'h0000);
    chk("reset.valid", {15'd0, valid_out}, 16'h0000);
    chk("reset.addr",  imem_addr, 16'h0000);
    $display("reset: instr=%04h imm=%04h pcn=%04h valid=%0b addr=%04h",
             instr_out, imm_out, pc_next_out, valid_out, imem_addr);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) step(vecs[i], $sformatf("vec%0d", i));

    // PC wrap: two-word SHR at 0xFFFF takes its immediate from address 0.
    mem[0] = 16'h0003;
    step(mk(0, 1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0006, 0, 16'hFFFF), "wrap_jump");
    step(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0006, 0, 16'h0000), "wrap_fetch");
    step(mk(0, 0, 16'h0000, 16'hF800, 16'h0003, 16'h0001, 1, 16'h0001), "wrap_imm");
    mem[0] = 16'hC800;

    // Asynchronous reset while waiting on an immediate.
    step(mk(0, 1, 16'h0004, 16'h0000, 16'h0000, 16'h0001, 0, 16'h0004), "areset_jump");
    step(mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, 16'h0005), "areset_simm");
    #2;
    rst = 1'b1;
    #1;
    chk("areset.instr", instr_out, 16'h0000);
    chk("areset.imm",   imm_out, 16'h0000);
    chk("areset.pcn",   pc_next_out, 16'h0000);
    chk("areset.valid", {15'd0, valid_out}, 16'h0000);
    chk("areset.addr",  imem_addr, 16'h0000);
    $display("areset: instr=%04h imm=%04h pcn=%04h valid=%0b addr=%04h",
             instr_out, imm_out, pc_next_out, valid_out, imem_addr);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(mk(0, 0, 16'h0000, 16'hC800, 16'h0000, 16'h0001, 1, 16'h0001), "restart0");
    step(mk(0, 0, 16'h0000, 16'h1800, 16'h0000, 16'h0002, 1, 16'h0002), "restart1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
